// File: rtl/fp_bcd_arb.sv
// Two-requester round-robin front end sharing one Q20.20 -> BCD converter.
// Each conversion scales by 10^6 (rounded), then runs a serial double-dabble over 40 bits.
module fp_bcd_arb #(
  parameter int N_DIG = 13,
  parameter int FRAC  = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               req_i,
  input  logic [2*FRAC-1:0]        val0_i,
  input  logic [2*FRAC-1:0]        val1_i,
  output logic [1:0]               ack_o,
  output logic                     busy_o,
  output logic                     out_valid_o,
  output logic                     out_id_o,
  output logic [4*(N_DIG-1)-1:0]   out_bcd_o,
  output logic                     out_ovf_o
);

  localparam int W  = 2 * FRAC;
  localparam int PW = W + 20;
  localparam int DW = 4 * N_DIG;
  localparam int CW = $clog2(W);
  localparam logic [PW-1:0] SCALE_K = PW'(1_000_000);

  typedef enum logic [1:0] {IDLE, SCALE, SHIFT} state_e;

  state_e         state_q, state_d;
  logic [1:0]     ack_q, ack_d;
  logic           valid_q, valid_d;
  logic [W-1:0]   op_q, op_d;
  logic           id_q, id_d;
  logic           last_q, last_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]  dig_q, dig_d;
  logic [DW-5:0]  bcd_q, bcd_d;
  logic           ovf_q, ovf_d;
  logic           out_id_q, out_id_d;

  logic [PW-1:0]   product;
  logic [W-1:0]    scaled;
  logic [FRAC-2:0] unused_frac;
  logic [DW-1:0]   dig_adj;
  logic            grant_id;

  // Bit FRAC-1 of the product is the first dropped fraction bit: adding it rounds half up.
  assign product     = {{(PW-W){1'b0}}, op_q} * SCALE_K;
  assign scaled      = product[PW-1:FRAC] + {{(W-1){1'b0}}, product[FRAC-1]};
  assign unused_frac = product[FRAC-2:0];

  always_comb begin
    dig_adj = dig_q;
    for (int i = 0; i < N_DIG; i++) begin
      if (dig_q[4*i +: 4] >= 4'd5) dig_adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
    end
  end

  // A lone request wins outright; on a tie the requester not served last time wins.
  always_comb begin
    unique case (req_i)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      default: grant_id = ~last_q;
    endcase
  end

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
    state_d  = state_q;
    ack_d    = 2'b00;
    valid_d  = 1'b0;
    op_d     = op_q;
    id_d     = id_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    dig_d    = dig_q;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;
    out_id_d = out_id_q;
    unique case (state_q)
      IDLE: begin
        if (|req_i) begin
          id_d    = grant_id;
          last_d  = grant_id;
          ack_d   = grant_id ? 2'b10 : 2'b01;
          op_d    = grant_id ? val1_i : val0_i;
          state_d = SCALE;
        end
      end
      SCALE: begin
        op_d    = scaled;
        dig_d   = '0;
        cnt_d   = CW'(W - 1);
        state_d = SHIFT;
      end
      SHIFT: begin
        dig_d = {dig_adj[DW-2:0], op_q[cnt_q]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          cnt_d    = '0;
          bcd_d    = dig_d[DW-5:0];
          ovf_d    = |dig_d[DW-1:DW-4];
          out_id_d = id_q;
          valid_d  = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ack_q    <= 2'b00;
      valid_q  <= 1'b0;
      op_q     <= '0;
      id_q     <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      dig_q    <= '0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
      out_id_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      valid_q  <= valid_d;
      op_q     <= op_d;
      id_q     <= id_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      dig_q    <= dig_d;
      bcd_q    <= bcd_d;
      ovf_q    <= ovf_d;
      out_id_q <= out_id_d;
    end
  end

  assign ack_o       = ack_q;
  assign busy_o      = (state_q == SCALE) || (state_q == SHIFT);
  assign out_valid_o = valid_q;
  assign out_id_o    = out_id_q;
  assign out_bcd_o   = bcd_q;
  assign out_ovf_o   = ovf_q;

endmodule

// File: tb/tb_fp_bcd_arb.sv
// Self-checking bench for fp_bcd_arb: fixed vectors, multi-cycle corner sequences,
// and random conversions checked against a decimal-arithmetic reference model.
module tb_fp_bcd_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_i;
  logic [39:0] val0_i, val1_i;
  logic [1:0]  ack_o;
  logic        busy_o, out_valid_o, out_id_o, out_ovf_o;
  logic [47:0] out_bcd_o;

  int errs   = 0;
  int checks = 0;
  logic exp_last;

  fp_bcd_arb dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .val0_i(val0_i), .val1_i(val1_i),
    .ack_o(ack_o), .busy_o(busy_o), .out_valid_o(out_valid_o), .out_id_o(out_id_o),
    .out_bcd_o(out_bcd_o), .out_ovf_o(out_ovf_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic [39:0] v0;
    logic [39:0] v1;
    logic [1:0]  ack;
    logic        id;
    logic [47:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: round(v * 10^6) in plain integer arithmetic, then decimal digit extraction.
  function automatic void ref_conv(input logic [39:0] v, output logic [47:0] bcd, output logic ovf);
    longint unsigned s;
    s   = ((64'(v) * 64'd1000000) + 64'd524288) / 64'd1048576;
    bcd = '0;
    for (int i = 0; i < 12; i++) begin
      bcd[4*i +: 4] = 4'(s % 64'd10);
      s = s / 64'd10;
    end
    ovf = (s % 64'd10) != 0;
  endfunction

  task automatic wait_ack(output logic [1:0] a, output int n);
    a = 2'b00;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (ack_o != 2'b00) begin
        a = ack_o;
        break;
      end
    end
  endtask

  // Counts cycles to out_valid; flags any cycle before it with busy low or an ack.
  task automatic wait_valid(output int n, output int bad);
    n   = 0;
    bad = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (out_valid_o) break;
      if (!busy_o || ack_o != 2'b00) bad++;
    end
  endtask

  task automatic do_conv(input logic [1:0] rq, input logic [39:0] v0, input logic [39:0] v1,
                         input logic [1:0] e_ack, input logic e_id, input logic [47:0] e_bcd,
                         input logic e_ovf, input string nm);
    logic [1:0] a;
    int n, bad;
    req_i  = rq;
    val0_i = v0;
    val1_i = v1;
    wait_ack(a, n);
    check({nm, " ack"}, 64'(a), 64'(e_ack));
    check({nm, " grant delay"}, 64'(n), 64'd1);
    req_i  = 2'b00;
    val0_i = {8'($urandom), 32'($urandom)};
    val1_i = {8'($urandom), 32'($urandom)};
    wait_valid(n, bad);
    check({nm, " latency"}, 64'(n), 64'd41);
    check({nm, " busy/ack in flight"}, 64'(bad), 64'd0);
    check({nm, " out_id"}, 64'(out_id_o), 64'(e_id));
    check({nm, " out_bcd"}, 64'(out_bcd_o), 64'(e_bcd));
    check({nm, " out_ovf"}, 64'(out_ovf_o), 64'(e_ovf));
    exp_last = e_id;
    @(negedge clk);
    check({nm, " valid pulse"}, 64'(out_valid_o), 64'd0);
    check({nm, " bcd hold"}, 64'(out_bcd_o), 64'(e_bcd));
  endtask

  initial begin
    logic [1:0]  a;
    logic [1:0]  rq;
    logic [39:0] v0, v1;
    logic [47:0] e_bcd;
    logic        e_ovf, e_id;
    int n, bad, vbad;

    vecs[0] = '{2'b01, 40'h00000_80000, 40'h0,            2'b01, 1'b0, 48'h000000500000, 1'b0};
    vecs[1] = '{2'b10, 40'h0,            40'h00000_00001, 2'b10, 1'b1, 48'h000000000001, 1'b0};
    vecs[2] = '{2'b01, 40'hF4240_00000, 40'h0,            2'b01, 1'b0, 48'h000000000000, 1'b1};
    vecs[3] = '{2'b10, 40'h0,            40'h00001_00000, 2'b10, 1'b1, 48'h000001000000, 1'b0};
    vecs[4] = '{2'b01, 40'h0,            40'hFF_FFFF_FFFF, 2'b01, 1'b0, 48'h000000000000, 1'b0};
    vecs[5] = '{2'b01, 40'hFF_FFFF_FFFF, 40'h0,           2'b01, 1'b0, 48'h048575999999, 1'b1};
    vecs[6] = '{2'b11, 40'h00000_C0000, 40'h00001_80000,  2'b10, 1'b1, 48'h000001500000, 1'b0};
    vecs[7] = '{2'b11, 40'h00000_C0000, 40'h00001_80000,  2'b01, 1'b0, 48'h000000750000, 1'b0};

    rst_n  = 1'b0;
    req_i  = 2'b00;
    val0_i = '0;
    val1_i = '0;
    exp_last = 1'b1;
    repeat (3) @(negedge clk);
    check("reset ack",       64'(ack_o), 64'd0);
    check("reset busy",      64'(busy_o), 64'd0);
    check("reset out_valid", 64'(out_valid_o), 64'd0);
    check("reset out_id",    64'(out_id_o), 64'd0);
    check("reset out_bcd",   64'(out_bcd_o), 64'd0);
    check("reset out_ovf",   64'(out_ovf_o), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_conv(vecs[i].req, vecs[i].v0, vecs[i].v1, vecs[i].ack, vecs[i].id,
              vecs[i].bcd, vecs[i].ovf, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 20; i++) begin
      rq = 2'($urandom_range(1, 3));
      v0 = {8'($urandom), 32'($urandom)};
      v1 = {8'($urandom), 32'($urandom)};
      if (i == 0) v0 = 40'h00000_7FFFF;
      e_id = (rq == 2'b01) ? 1'b0 : (rq == 2'b10) ? 1'b1 : ~exp_last;
      ref_conv(e_id ? v1 : v0, e_bcd, e_ovf);
      do_conv(rq, v0, v1, e_id ? 2'b10 : 2'b01, e_id, e_bcd, e_ovf, $sformatf("rand%0d", i));
    end

    // Both requesters held high from reset release: strict alternation, 42 cycles apart.
    rst_n  = 1'b0;
    req_i  = 2'b11;
    val0_i = 40'h00003_40000;
    val1_i = 40'h12345_ABCDE;
    exp_last = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int g = 0; g < 4; g++) begin
      wait_ack(a, n);
      check($sformatf("rr%0d ack", g), 64'(a), (g % 2 == 0) ? 64'd1 : 64'd2);
      check($sformatf("rr%0d gap", g), 64'(g == 0 ? n : n + 41), (g == 0) ? 64'd1 : 64'd42);
      wait_valid(n, bad);
      check($sformatf("rr%0d latency", g), 64'(n), 64'd41);
      check($sformatf("rr%0d busy/ack in flight", g), 64'(bad), 64'd0);
      ref_conv((g % 2 == 0) ? val0_i : val1_i, e_bcd, e_ovf);
      check($sformatf("rr%0d out_bcd", g), 64'(out_bcd_o), 64'(e_bcd));
      check($sformatf("rr%0d out_id", g), 64'(out_id_o), 64'(g % 2));
    end
    req_i = 2'b00;
    @(negedge clk);

    // Reset pulse ten cycles into SHIFT aborts the conversion; the still-held request is regranted.
    req_i  = 2'b01;
    val0_i = 40'h00007_20000;
    wait_ack(a, n);
    check("abort first ack", 64'(a), 64'd1);
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort busy",      64'(busy_o), 64'd0);
    check("abort ack",       64'(ack_o), 64'd0);
    check("abort out_valid", 64'(out_valid_o), 64'd0);
    check("abort out_bcd",   64'(out_bcd_o), 64'd0);
    check("abort out_id",    64'(out_id_o), 64'd0);
    vbad = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid_o || busy_o) vbad++;
    end
    check("abort quiet in reset", 64'(vbad), 64'd0);
    rst_n = 1'b1;
    exp_last = 1'b1;
    ref_conv(40'h00007_20000, e_bcd, e_ovf);
    do_conv(2'b01, 40'h00007_20000, 40'h0, 2'b01, 1'b0, e_bcd, e_ovf, "post-abort");

    // Requester 1 arrives mid-conversion: held off until IDLE, then granted on the first edge.
    req_i  = 2'b01;
    val0_i = 40'h00010_00000;
    wait_ack(a, n);
    check("late ack0", 64'(a), 64'd1);
    repeat (5) @(negedge clk);
    req_i  = 2'b11;
    val1_i = 40'h00000_40000;
    wait_valid(n, bad);
    check("late remaining latency", 64'(n), 64'd36);
    check("late no ack while busy", 64'(bad), 64'd0);
    check("late first out_bcd", 64'(out_bcd_o), 64'h000016000000);
    req_i = 2'b10;
    wait_ack(a, n);
    check("late ack1", 64'(a), 64'd2);
    check("late ack1 delay", 64'(n), 64'd1);
    req_i = 2'b00;
    wait_valid(n, bad);
    check("late second latency", 64'(n), 64'd41);
    check("late second out_id", 64'(out_id_o), 64'd1);
    check("late second out_bcd", 64'(out_bcd_o), 64'h000000250000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fp_bcd_arb.md
FP_BCD_ARB -- requirements
Module: fp_bcd_arb

Interface
REQ-001 Parameter N_DIG, 13, number of BCD digits computed internally; the low 12 are output.
REQ-002 Parameter FRAC, 20, fraction bits of the unsigned Q20.20 input format.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset; assertion clears all state immediately, independent of clk.
REQ-005 req  input  2  per-requester conversion request; held high until the matching ack.
REQ-006 val0  input  40  requester 0 operand, unsigned Q20.20.
REQ-007 val1  input  40  requester 1 operand, unsigned Q20.20.
REQ-008 ack  output  2  one-hot, one-cycle grant pulse; operand captured at the same edge.
REQ-009 busy  output  1  high while a conversion is in flight (states SCALE or SHIFT).
REQ-010 out_valid  output  1  one-cycle pulse; result fields valid in this cycle.
REQ-011 out_id  output  1  requester index of the result.
REQ-012 out_bcd  output  48  12 BCD digits of round(val*10^6); bits [3:0] = least significant digit.
REQ-013 out_ovf  output  1  set when the 13th digit is nonzero (integer part >= 1,000,000).

Function
REQ-014 FSM states: IDLE, SCALE, SHIFT; exactly one converter shared by both requesters.
REQ-015 IDLE: on an edge with any req bit high -> capture the granted operand, ack[k]=1 for the next cycle, go to SCALE; otherwise stay.
REQ-016 Arbitration is round-robin: one request -> grant it; both -> grant the index != last_id; last_id updates on every grant.
REQ-017 SCALE (1 cycle): product = operand*1,000,000 (60 bits); scaled = product[59:20] + product[19] (round half up), kept at 40 bits; load the shift source, clear the 52-bit digit register, set the bit counter to 39; go to SHIFT.
REQ-018 SHIFT: each cycle, add 3 to every 4-bit digit >= 5, then shift the digit register left 1 with scaled[counter] entering bit 0; decrement the counter.
REQ-019 On the SHIFT edge with counter==0: load out_bcd = digits[47:0], out_ovf = (digits[51:48] != 0), and out_id; pulse out_valid; go to IDLE.
REQ-020 Latency: if edge E grants, out_valid is high in the cycle after edge E+41; minimum grant-to-grant period is 42 cycles.
REQ-021 req is ignored outside IDLE; a pending request is held off (no ack) until the FSM returns to IDLE.
REQ-022 Operands change only at a grant edge; val0/val1 may change freely at other times.
REQ-023 out_bcd, out_ovf and out_id hold their values until the next out_valid.
REQ-024 ack and out_valid never assert in the same cycle for the same conversion; at most one ack bit is high per cycle.
REQ-025 Maximum input 0xFF_FFFF_FFFF scales to < 2^40; no scaled-value truncation is possible.

Reset
REQ-026 While rst_n=0: state=IDLE, ack=0, busy=0, out_valid=0, out_id=0, out_bcd=0, out_ovf=0, counter=0, last_id=1 (requester 0 wins the first tie).
REQ-027 Reset during SCALE/SHIFT aborts the conversion; no out_valid is generated for it; requester re-requests after release.
REQ-028 The first grant can occur on the first rising edge after rst_n deasserts.

Verification
REQ-029 req=01, val0=0x00000_80000 (0.5) -> ack=01 for 1 cycle; out_valid 41 cycles later, out_id=0, out_bcd=0x000000500000, out_ovf=0.
REQ-030 req=10, val1=0x00000_00001 (2^-20) -> product 0xF4240, bit19=1 -> out_bcd=0x000000000001, out_id=1 (rounding check).
REQ-031 val0=0xF4240_00000 (1,000,000.0) -> out_bcd=0x000000000000, out_ovf=1.
REQ-032 After reset, req=11 held continuously -> grant order 0,1,0,1; grant edges exactly 42 cycles apart; busy high between each grant and its out_valid.
REQ-033 rst_n pulsed low 10 cycles into SHIFT -> outputs cleared, no out_valid; after release with req0 still high -> fresh ack=01 and a correct result 41 cycles after the grant edge.
REQ-034 req1 raised during a requester-0 conversion -> no ack while busy; ack=10 on the first edge back in IDLE.
